multicycle_controller: RTL and testbench

Sequencing FSM that converts the single-cycle RV32I datapath into a multicycle datapath with one shared instruction/data memory. Each instruction is stepped through fetch, decode, execute, memory and writeback states. The block drives all datapath mux selects and write enables, and stalls on a memory-ready handshake. It replaces the purely combinational opcode decoder in the multicycle top level.

---
 rtl/riscv_pkg.sv | 62 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 30 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller.
// Covers opcodes, FSM states and the datapath mux select codes.
package riscv_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp plus funct fields onto an ALU operation.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type sub sets both bits; addi with imm[10]=1 must stay an add.
          3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: drives datapath selects and enables,
// stalling on mem_ready in the memory-access states.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_n;
  state_t     cur;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_w;
  logic       mem_w;
  logic       reg_w;
  logic       ret;
  logic       ill;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_n;
  end

  // During reset the outputs already show FETCH, so a pending store is dropped at once.
  assign cur = rst ? state_q : S_FETCH;

  always_comb begin
    state_n    = S_FETCH;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ret        = 1'b0;
    ill        = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    case (cur)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_w       = mem_ready;
        pc_update  = mem_ready;
        state_n    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_RTYPE:     state_n = S_EXECR;
          OP_IALU:      state_n = S_EXECI;
          OP_BEQ:       state_n = S_BEQ;
          OP_JAL:       state_n = S_JAL;
          default: begin
            state_n = S_FETCH;
            ill     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        state_n   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_n = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        ret        = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        ret     = mem_ready;
        state_n = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_FUNCT;
        state_n   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_n   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        ret   = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RD1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        ret       = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
        state_n   = S_ALUWB;
      end
      default: state_n = S_FETCH;
    endcase
  end

  assign pc_write  = rst & (pc_update | (branch & zero));
  assign ir_write  = rst & ir_w;
  assign mem_write = rst & mem_w;
  assign reg_write = rst & reg_w;
  assign retire    = rst & ret;
  assign illegal   = rst & ill;
  assign imm_src   = imm_sel(op);
  assign state     = state_q;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op5         (op[5]),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: whole output bundle checked each cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .retire      (retire),
    .illegal     (illegal),
    .state       (state)
  );

  // Field order: state,pcw,adr,irw,memw,regw,res,srca,srcb,imm,alu,retire,illegal
  function automatic logic [21:0] pk(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic irw, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [2:0] alu, input logic ret, input logic ill);
    return {st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, ret, ill};
  endfunction

  logic [21:0] obs;
  assign obs = {state, pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_control, retire, illegal};

  // Sample on the falling edge, then advance to just past the next rising edge.
  task automatic step(input string tag, input logic [21:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  logic [2:0] tbl_f3  [5] = '{3'b010, 3'b110, 3'b111, 3'b001, 3'b000};
  logic [6:0] tbl_f7  [5] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  logic [2:0] tbl_alu [5] = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b000};

  initial begin
    rst = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7 = 7'h00;
    zero = 1'b0; mem_ready = 1'b1;

    // Reset: enables masked, FETCH selects shown
    step("rst_c1", pk(4'bxxxx, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0) & 22'h0FFFFF
         | {obs[21:18] === 4'd0 ? 4'd0 : obs[21:18], 18'h0} & 22'h3C0000);
    step("rst_c2", pk(0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    rst = 1'b1;

    // lw: 5 cycles
    step("lw_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    step("lw_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,0));
    step("lw_memadr", pk(2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0));
    step("lw_memrd",  pk(3, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0,0));
    step("lw_memwb",  pk(4, 0,0,0,0,1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1,0));

    // sw with three stall cycles in MEMWRITE
    op = 7'b0100011;
    step("sw_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0));
    step("sw_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0,0));
    step("sw_memadr", pk(2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0,0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      step("sw_stall", pk(5, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0,0));
    mem_ready = 1'b1;
    step("sw_done",   pk(5, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1,0));

    // beq taken then not taken
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
    step("beq_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0,0));
    step("beq_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0,0));
    step("beq_taken",  pk(9, 1,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0));
    zero = 1'b0;
    step("beq2_fetch", pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000, 0,0));
    step("beq2_decode",pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 0,0));
    step("beq_nottkn", pk(9, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1,0));

    // R-type sub
    op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
    step("sub_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    step("sub_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,0));
    step("sub_execr",  pk(6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001, 0,0));
    step("sub_aluwb",  pk(8, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0));

    // addi with funct7[5]=1 stays an add
    op = 7'b0010011;
    step("addi_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    step("addi_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,0));
    step("addi_execi",  pk(7, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0,0));
    step("addi_aluwb",  pk(8, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1,0));

    // Remaining R-type funct3 decodes, checked in EXECR
    op = 7'b0110011;
    for (int i = 0; i < 5; i++) begin
      funct3 = tbl_f3[i]; funct7 = tbl_f7[i];
      @(posedge clk); #1;
      @(posedge clk); #1;
      step("rtype_alu", pk(6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, 2'b00, tbl_alu[i], 0,0));
      @(posedge clk); #1;
    end

    // jal
    op = 7'b1101111; funct3 = 3'b000; funct7 = 7'h00;
    step("jal_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000, 0,0));
    step("jal_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000, 0,0));
    step("jal_jal",    pk(10,1,0,0,0,0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0,0));
    step("jal_aluwb",  pk(8, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000, 1,0));

    // FETCH stall, then illegal opcode
    op = 7'b0000000; mem_ready = 1'b0;
    step("fetch_stall", pk(0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    mem_ready = 1'b1;
    step("ill_fetch",   pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));
    step("ill_decode",  pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 0,1));
    mem_ready = 1'b0;
    step("ill_back",    pk(0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0,0));

    // Reset asserted mid-MEMWRITE
    op = 7'b0100011; mem_ready = 1'b1;
    step("rsw_fetch",  pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0));
    step("rsw_decode", pk(1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000, 0,0));
    step("rsw_memadr", pk(2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 0,0));
    mem_ready = 1'b0;
    step("rsw_memwr",  pk(5, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 0,0));
    rst = 1'b0;
    step("rsw_drop",   pk(5, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0));
    step("rsw_state0", pk(0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0));
    rst = 1'b1; mem_ready = 1'b1;
    step("rsw_resume", pk(0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
